// File: rtl/hilo_seq_ctrl.sv
// hilo_seq_ctrl: issue sequencer for a single-issue ALU with a HI/LO pair.
//
// A request is latched into the alu_* registers when the controller is not
// busy. The controller then waits a fixed number of EXEC cycles and captures
// the ALU result. Multiply (fs=5'h1E) and divide (fs=5'h1F) take MD_CYCLES
// EXEC cycles and write HI/LO. Every other function takes one EXEC cycle.
//
// Optional feature: define DIV_ZERO_TRAP_EN to trap a divide by zero.
// The trapped divide takes one EXEC cycle and leaves HI/LO unchanged. It
// returns y_lo=0 and cvnz=0, and it raises dz_err.
// Without the macro, dz_err is tied to 0.
//
// Handshake: start is a request qualified by busy. A request is taken on a
// rising edge where start=1 and busy=0; there is no queueing. done pulses
// for exactly one cycle when the results become valid. done can be followed
// directly by the next EXEC when start is high during the DONE cycle.
//
// Reset is synchronous and active-high. It wins over start and drops any
// in-flight operation without producing a done pulse.

module hilo_seq_ctrl #(
  parameter int MD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  fs,
  input  logic [31:0] s_in,
  input  logic [31:0] t_in,
  input  logic [4:0]  shamt_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] alu_s,
  output logic [31:0] alu_t,
  output logic [4:0]  alu_fs,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_y_hi,
  input  logic [31:0] alu_y_lo,
  input  logic [3:0]  alu_cvnz,
  output logic [31:0] y_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [3:0]  cvnz,
  output logic        dz_err
);

  localparam logic [4:0] FS_MPY  = 5'h1E;
  localparam logic [4:0] FS_DIV  = 5'h1F;
  // The counter holds the number of EXEC cycles that remain after the current one.
  localparam logic [3:0] MD_LAST = 4'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;

  logic       req_md;
  logic       req_dz;
  logic [3:0] req_last;
  logic       cap_md;
  logic       cap_dz;

  // Classify the incoming request and the op in flight.
  always_comb begin
    req_md = (fs == FS_MPY) || (fs == FS_DIV);
    cap_md = (alu_fs == FS_MPY) || (alu_fs == FS_DIV);
`ifdef DIV_ZERO_TRAP_EN
    req_dz = (fs == FS_DIV) && (t_in == 32'd0);
    cap_dz = (alu_fs == FS_DIV) && (alu_t == 32'd0);
`else
    req_dz = 1'b0;
    cap_dz = 1'b0;
`endif
    req_last = (req_md && !req_dz) ? MD_LAST : 4'd0;
  end

`ifndef DIV_ZERO_TRAP_EN
  // Without the trap, divide by zero runs as an ordinary divide and no error is reported.
  assign dz_err = 1'b0;
`endif

  // Sequencer FSM with registered busy/done and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_s     <= 32'd0;
      alu_t     <= 32'd0;
      alu_fs    <= 5'd0;
      alu_shamt <= 5'd0;
      y_lo      <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      cvnz      <= 4'd0;
`ifdef DIV_ZERO_TRAP_EN
      dz_err    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            alu_s     <= s_in;
            alu_t     <= t_in;
            alu_fs    <= fs;
            alu_shamt <= shamt_in;
            cnt       <= req_last;
            busy      <= 1'b1;
            state     <= S_EXEC;
          end else begin
            state <= S_IDLE;
          end
        end

        S_EXEC: begin
          if (cnt == 4'd0) begin
            if (cap_dz) begin
              y_lo <= 32'd0;
              cvnz <= 4'd0;
`ifdef DIV_ZERO_TRAP_EN
              dz_err <= 1'b1;
`endif
            end else begin
              y_lo <= alu_y_lo;
              if (cap_md) begin
                // Multiply and divide never carry or overflow, so C and V are cleared.
                cvnz <= {2'b00, alu_cvnz[1:0]};
                hi   <= alu_y_hi;
                lo   <= alu_y_lo;
              end else begin
                cvnz <= alu_cvnz;
              end
`ifdef DIV_ZERO_TRAP_EN
              dz_err <= 1'b0;
`endif
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
